// File: rtl/rom_loader_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// rom_loader_pkg : shared state encoding, default indices and FIFO entry type
// Rev 1.0
// ----------------------------------------------------------------------------
package rom_loader_pkg;

  localparam logic [7:0] ROM_INDEX_DEFAULT = 8'd0;
  localparam logic [7:0] DIP_INDEX_DEFAULT = 8'd254;

  // Loader FSM state encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_DRAIN  = 3'd2;
  localparam state_t ST_SETTLE = 3'd3;
  localparam state_t ST_READY  = 3'd4;

  typedef struct packed {
    logic [17:0] addr;
    logic [7:0]  data;
  } dl_entry_t;

endpackage
`default_nettype wire

// File: rtl/rom_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// rom_loader_if : hps_io download bus and core ROM write bus
// Rev 1.0
// ----------------------------------------------------------------------------
interface rom_loader_ioctl_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait
  );
  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait
  );
endinterface

interface rom_loader_dl_if;
  logic [17:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_wr;
  logic        dl_ready;

  modport master (
    output dl_addr, dl_data, dl_wr,
    input  dl_ready
  );
  modport slave (
    input  dl_addr, dl_data, dl_wr,
    output dl_ready
  );
endinterface
`default_nettype wire

// File: rtl/rom_loader_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// rom_loader_fifo : 2-entry FIFO, head visible the cycle after the first push
// Rev 1.0
// ----------------------------------------------------------------------------
module rom_loader_fifo #(
  parameter int WIDTH = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  // The caller only pushes when not full and only pops when valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({push, pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rdata = r_mem[r_rd_ptr];
  assign valid = (r_count != 2'd0);
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/rom_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// rom_loader : buffers an hps_io ROM download to the core and captures DIP bytes
// Rev 1.0
// ----------------------------------------------------------------------------
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter logic [7:0]  ROM_INDEX     = ROM_INDEX_DEFAULT,
  parameter logic [7:0]  DIP_INDEX     = DIP_INDEX_DEFAULT,
  parameter logic [17:0] ROM_BYTES     = 18'h28000,
  parameter int          SETTLE_CYCLES = 16
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  rom_loader_ioctl_if.slave    ioctl,
  rom_loader_dl_if.master      dl,
  output logic [63:0]          dip_sw,
  output logic                 core_reset,
  output logic                 rom_ready,
  output logic                 err_range,
  output logic                 err_short
);

  state_t      r_state;
  logic        r_dl_prev;
  logic [17:0] r_byte_cnt;
  logic [15:0] r_settle_cnt;
  logic        r_wait;
  logic        r_err_range;
  logic        r_err_short;
  logic [63:0] r_dip;

  dl_entry_t   w_entry;
  dl_entry_t   w_head;
  logic        w_fifo_valid;
  logic [1:0]  w_fifo_count;
  logic        w_full;
  logic        w_rise;
  logic        w_fall;
  logic        w_in_range;
  logic        w_rom_wr;
  logic        w_push;
  logic        w_pop;
  logic        w_dip_wr;

  assign w_rise       = ioctl.ioctl_download & ~r_dl_prev;
  assign w_fall       = ~ioctl.ioctl_download & r_dl_prev;
  assign w_in_range   = (ioctl.ioctl_addr < {7'd0, ROM_BYTES});
  assign w_full       = (w_fifo_count == 2'd2);
  assign w_rom_wr     = (r_state == ST_LOAD) && ioctl.ioctl_wr && (ioctl.ioctl_index == ROM_INDEX);
  assign w_push       = w_rom_wr && w_in_range && !w_full;
  assign w_pop        = w_fifo_valid && dl.dl_ready;
  assign w_dip_wr     = ioctl.ioctl_wr && (ioctl.ioctl_index == DIP_INDEX) &&
                        (ioctl.ioctl_addr[24:3] == 22'd0);
  assign w_entry.addr = ioctl.ioctl_addr[17:0];
  assign w_entry.data = ioctl.ioctl_dout;

  rom_loader_fifo #(
    .WIDTH ($bits(dl_entry_t))
  ) u_fifo (
    .clk   (clk_sys),
    .rst   (reset),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_entry),
    .rdata (w_head),
    .valid (w_fifo_valid),
    .count (w_fifo_count)
  );

  // r_dl_prev resets high so a download still active across reset is not
  // mistaken for a fresh rising edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_dl_prev    <= 1'b1;
      r_byte_cnt   <= '0;
      r_settle_cnt <= '0;
      r_wait       <= 1'b0;
      r_err_range  <= 1'b0;
      r_err_short  <= 1'b0;
      r_dip        <= '0;
    end else begin
      r_dl_prev <= ioctl.ioctl_download;
      r_wait    <= w_full || ((w_fifo_count == 2'd1) && w_push && !w_pop);

      if (w_dip_wr) begin
        r_dip[{ioctl.ioctl_addr[2:0], 3'b000} +: 8] <= ioctl.ioctl_dout;
      end
      if (w_rom_wr && !w_push) begin
        r_err_range <= 1'b1;
      end
      if (w_push && (r_byte_cnt != 18'h3FFFF)) begin
        r_byte_cnt <= r_byte_cnt + 18'd1;
      end

      case (r_state)
        ST_IDLE, ST_READY: begin
          if (w_rise && (ioctl.ioctl_index == ROM_INDEX)) begin
            r_state     <= ST_LOAD;
            r_err_range <= 1'b0;
            r_err_short <= 1'b0;
            r_byte_cnt  <= '0;
          end
        end
        ST_LOAD: begin
          if (w_fall) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!w_fifo_valid) begin
            r_state      <= ST_SETTLE;
            r_err_short  <= (r_byte_cnt < ROM_BYTES);
            r_settle_cnt <= '0;
          end
        end
        ST_SETTLE: begin
          if (r_settle_cnt == 16'(SETTLE_CYCLES - 1)) begin
            r_state <= ST_READY;
          end else begin
            r_settle_cnt <= r_settle_cnt + 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dl.dl_wr         = w_fifo_valid;
  assign dl.dl_addr       = w_head.addr;
  assign dl.dl_data       = w_head.data;
  assign ioctl.ioctl_wait = r_wait;
  assign dip_sw           = r_dip;
  assign core_reset       = (r_state != ST_READY);
  assign rom_ready        = (r_state == ST_READY);
  assign err_range        = r_err_range;
  assign err_short        = r_err_short;

endmodule
`default_nettype wire

// File: tb/tb_rom_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rom_loader : directed stimulus with a queue-based reference model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_rom_loader;

  localparam logic [17:0] RB = 18'h00200;
  localparam int          SC = 16;
  localparam int M_IDLE = 0, M_LOAD = 1, M_DRAIN = 2, M_SETTLE = 3, M_READY = 4;

  logic clk_sys = 1'b0;
  logic reset;
  always #5 clk_sys = ~clk_sys;

  rom_loader_ioctl_if io ();
  rom_loader_dl_if    dlb ();
  logic [63:0] dip_sw;
  logic        core_reset, rom_ready, err_range, err_short;

  rom_loader #(
    .ROM_INDEX     (8'd0),
    .DIP_INDEX     (8'd254),
    .ROM_BYTES     (RB),
    .SETTLE_CYCLES (SC)
  ) dut (
    .clk_sys    (clk_sys),
    .reset      (reset),
    .ioctl      (io),
    .dl         (dlb),
    .dip_sw     (dip_sw),
    .core_reset (core_reset),
    .rom_ready  (rom_ready),
    .err_range  (err_range),
    .err_short  (err_short)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is a queue of {addr,data}, settle is a countdown.
  bit          m_valid = 1'b0;
  int          m_phase;
  bit          m_prev;
  logic [25:0] m_q[$];
  int          m_cnt;
  bit          m_err_r, m_err_s, m_wait;
  logic [63:0] m_dip;
  int          m_left;
  int          cyc = 0, n_hs = 0, last_hs_cyc = 0, ready_rise_cyc = 0;
  bit          ready_q = 1'b0;

  always @(negedge clk_sys) begin
    bit rise, fall, pop, rom_wr, inr, push;
    int occ, b;
    cyc++;
    if (m_valid) begin
      chk("core_reset", 64'(core_reset), 64'(m_phase != M_READY));
      chk("rom_ready",  64'(rom_ready),  64'(m_phase == M_READY));
      chk("err_range",  64'(err_range),  64'(m_err_r));
      chk("err_short",  64'(err_short),  64'(m_err_s));
      chk("ioctl_wait", 64'(io.ioctl_wait), 64'(m_wait));
      chk("dl_wr",      64'(dlb.dl_wr),  64'(m_q.size() > 0));
      chk("dip_sw",     dip_sw,          m_dip);
      if (m_q.size() > 0) begin
        chk("dl_addr", 64'(dlb.dl_addr), 64'(m_q[0][25:8]));
        chk("dl_data", 64'(dlb.dl_data), 64'(m_q[0][7:0]));
      end
    end
    if (dlb.dl_wr && dlb.dl_ready) begin
      n_hs++;
      last_hs_cyc = cyc;
    end
    if (rom_ready && !ready_q) ready_rise_cyc = cyc;
    ready_q = rom_ready;

    if (reset) begin
      m_valid = 1'b1; m_phase = M_IDLE; m_prev = 1'b1; m_q.delete(); m_cnt = 0;
      m_err_r = 1'b0; m_err_s = 1'b0; m_wait = 1'b0; m_dip = '0; m_left = 0;
    end else if (m_valid) begin
      rise   = io.ioctl_download && !m_prev;
      fall   = !io.ioctl_download && m_prev;
      occ    = m_q.size();
      pop    = (occ > 0) && dlb.dl_ready;
      rom_wr = (m_phase == M_LOAD) && io.ioctl_wr && (io.ioctl_index == 8'd0);
      inr    = (io.ioctl_addr < {7'd0, RB});
      push   = rom_wr && inr && (occ < 2);
      m_wait = (occ == 2) || (occ == 1 && push && !pop);
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back({io.ioctl_addr[17:0], io.ioctl_dout});
        if (m_cnt < 262143) m_cnt++;
      end
      if (rom_wr && !push) m_err_r = 1'b1;
      if (io.ioctl_wr && io.ioctl_index == 8'd254 && io.ioctl_addr[24:3] == 22'd0) begin
        b = int'(io.ioctl_addr[2:0]);
        m_dip[b*8 +: 8] = io.ioctl_dout;
      end
      case (m_phase)
        M_IDLE, M_READY:
          if (rise && io.ioctl_index == 8'd0) begin
            m_phase = M_LOAD; m_err_r = 1'b0; m_err_s = 1'b0; m_cnt = 0;
          end
        M_LOAD:  if (fall) m_phase = M_DRAIN;
        M_DRAIN:
          if (occ == 0) begin
            m_phase = M_SETTLE; m_err_s = (m_cnt < int'(RB)); m_left = SC;
          end
        M_SETTLE: if (m_left == 1) m_phase = M_READY; else m_left--;
        default: m_phase = M_IDLE;
      endcase
      m_prev = io.ioctl_download;
    end
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wr_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d,
                         input bit honor_wait);
    int n = 0;
    while (honor_wait && io.ioctl_wait && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++; failures++;
      $display("FAIL wait_timeout: ioctl_wait=1 required=0 after %0d cycles", n);
    end
    io.ioctl_index = idx; io.ioctl_addr = a; io.ioctl_dout = d; io.ioctl_wr = 1'b1;
    tick();
    io.ioctl_wr = 1'b0;
  endtask

  task automatic start_load();
    io.ioctl_index = 8'd0;
    io.ioctl_download = 1'b1;
    tick();
  endtask

  task automatic send_bytes(input int nbytes);
    for (int i = 0; i < nbytes; i++)
      wr_byte(8'd0, 25'(i), 8'((i * 37 + 5) & 255), 1'b1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!rom_ready && n < 300) begin
      tick();
      n++;
    end
    if (!rom_ready) begin
      checks++; failures++;
      $display("FAIL ready_timeout: rom_ready=0 required=1 after %0d cycles", n);
    end
    tick();
  endtask

  // Last pop at cycle k, DRAIN sees empty at k+1, SETTLE spans SC cycles, READY at k+SC+2.
  task automatic full_load();
    int base;
    base = n_hs;
    dlb.dl_ready = 1'b1;
    start_load();
    send_bytes(int'(RB));
    io.ioctl_download = 1'b0;
    wait_ready();
    chk("handshakes",  64'(n_hs - base), 64'(RB));
    chk("ready_delay", 64'(ready_rise_cyc - last_hs_cyc), 64'(SC + 2));
    chk("full_err_short", 64'(err_short), 64'd0);
    chk("full_rom_ready", 64'(rom_ready), 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    io.ioctl_download = 1'b0; io.ioctl_index = 8'd0; io.ioctl_wr = 1'b0;
    io.ioctl_addr = '0; io.ioctl_dout = '0; dlb.dl_ready = 1'b1;
    repeat (3) tick();
    chk("rst_core_reset", 64'(core_reset), 64'd1);
    chk("rst_rom_ready",  64'(rom_ready),  64'd0);
    chk("rst_dl_wr",      64'(dlb.dl_wr),  64'd0);
    chk("rst_dl_addr",    64'(dlb.dl_addr), 64'd0);
    chk("rst_dl_data",    64'(dlb.dl_data), 64'd0);
    chk("rst_wait",       64'(io.ioctl_wait), 64'd0);
    chk("rst_dip",        dip_sw, 64'd0);
    chk("rst_errs",       64'({err_range, err_short}), 64'd0);
    reset = 1'b0;
    repeat (3) tick();

    // DIP capture: addr 8 is outside the 8-byte window, index 7 is foreign
    wr_byte(8'd254, 25'd0, 8'h5A, 1'b1);
    wr_byte(8'd254, 25'd8, 8'hFF, 1'b1);
    wr_byte(8'd254, 25'd3, 8'hC3, 1'b1);
    wr_byte(8'd7,   25'd1, 8'h99, 1'b1);
    tick();
    chk("dip_value", dip_sw, 64'h0000_0000_C300_005A);

    full_load();

    // Short load of 0x100 bytes
    start_load();
    send_bytes(256);
    io.ioctl_download = 1'b0;
    wait_ready();
    chk("short_err_short", 64'(err_short), 64'd1);
    chk("short_rom_ready", 64'(rom_ready), 64'd1);

    // Out-of-range writes must not count: 511 good bytes still leave the load short
    start_load();
    wr_byte(8'd0, 25'(RB), 8'hEE, 1'b1);
    chk("oob_err_range", 64'(err_range), 64'd1);
    chk("oob_dl_wr",     64'(dlb.dl_wr), 64'd0);
    wr_byte(8'd0, 25'h1FFFFFF, 8'h11, 1'b1);
    send_bytes(int'(RB) - 1);
    io.ioctl_download = 1'b0;
    wait_ready();
    chk("oob_err_short", 64'(err_short), 64'd1);
    chk("oob_err_range_end", 64'(err_range), 64'd1);

    // Backpressure: third byte hits a full FIFO
    dlb.dl_ready = 1'b0;
    start_load();
    wr_byte(8'd0, 25'd0, 8'hA0, 1'b0);
    wr_byte(8'd0, 25'd1, 8'hA1, 1'b0);
    chk("bp_wait", 64'(io.ioctl_wait), 64'd1);
    wr_byte(8'd0, 25'd2, 8'hA2, 1'b0);
    chk("bp_err_range", 64'(err_range), 64'd1);
    repeat (5) tick();
    chk("bp_hold_addr", 64'(dlb.dl_addr), 64'd0);
    chk("bp_hold_data", 64'(dlb.dl_data), 64'hA0);
    dlb.dl_ready = 1'b1;
    repeat (3) tick();
    io.ioctl_download = 1'b0;
    wait_ready();
    chk("bp_err_short", 64'(err_short), 64'd1);

    // Reset mid-load with bytes buffered and download still high
    dlb.dl_ready = 1'b0;
    start_load();
    wr_byte(8'd0, 25'd0, 8'h33, 1'b1);
    wr_byte(8'd0, 25'd1, 8'h44, 1'b1);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    dlb.dl_ready = 1'b1;
    repeat (3) tick();
    chk("mid_dl_wr",      64'(dlb.dl_wr), 64'd0);
    chk("mid_core_reset", 64'(core_reset), 64'd1);
    wr_byte(8'd0, 25'd5, 8'h55, 1'b1);
    tick();
    chk("mid_idle_ignore", 64'(dlb.dl_wr), 64'd0);
    io.ioctl_download = 1'b0;
    repeat (2) tick();
    full_load();

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 SHALL have parameter ROM_INDEX, default 8'd0, ioctl_index value selecting the ROM download.
REQ-002 SHALL have parameter DIP_INDEX, default 8'd254, ioctl_index value selecting the DIP download.
REQ-003 SHALL have parameter ROM_BYTES, default 18'h28000, ROM image size; higher addresses are out of range.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 16, post-load reset hold length in clk_sys cycles.
REQ-005 SHALL have port clk_sys  in  1  system clock; the only clock.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port ioctl_download  in  1  download-active level from hps_io.
REQ-008 SHALL have port ioctl_index  in  8  download index.
REQ-009 SHALL have port ioctl_wr  in  1  single-cycle byte strobe.
REQ-010 SHALL have port ioctl_addr  in  25  byte address.
REQ-011 SHALL have port ioctl_dout  in  8  byte data.
REQ-012 SHALL have port ioctl_wait  out  1  throttle to hps_io.
REQ-013 SHALL have port dl_addr  out  18  ROM write address to the core.
REQ-014 SHALL have port dl_data  out  8  ROM write data.
REQ-015 SHALL have port dl_wr  out  1  write valid.
REQ-016 SHALL have port dl_ready  in  1  core accepts dl_wr this cycle.
REQ-017 SHALL have port dip_sw  out  64  DIP bytes; byte k on bits [8k+7:8k].
REQ-018 SHALL have port core_reset  out  1  reset for the game core.
REQ-019 SHALL have port rom_ready  out  1  ROM complete and valid.
REQ-020 SHALL have port err_range  out  1  sticky: an out-of-range ROM byte was received.
REQ-021 SHALL have port err_short  out  1  sticky: the last ROM load ended with fewer than ROM_BYTES bytes.

Function
REQ-022 SHALL run an FSM with states IDLE, LOAD, DRAIN, SETTLE and READY.
REQ-023 SHALL go IDLE->LOAD or READY->LOAD on the rising edge of ioctl_download while ioctl_index==ROM_INDEX, clearing err_range, err_short and the byte counter.
REQ-024 SHALL go LOAD->DRAIN on the falling edge of ioctl_download.
REQ-025 SHALL go DRAIN->SETTLE on the first cycle the buffer is empty, setting err_short if the byte counter < ROM_BYTES.
REQ-026 SHALL count in SETTLE exactly SETTLE_CYCLES cycles, then enter READY.
REQ-027 SHALL drive rom_ready=1 only in READY, and core_reset=1 in every other state.
REQ-028 SHALL push ioctl_wr in LOAD with ioctl_addr<ROM_BYTES into a 2-entry FIFO of {addr[17:0],data}, and increment an 18-bit saturating byte counter on each push.
REQ-029 SHALL discard ioctl_wr in LOAD with ioctl_addr>=ROM_BYTES, set err_range, and leave the counter unchanged.
REQ-030 SHALL present the FIFO head on dl_addr/dl_data, with dl_wr=1 while the FIFO is non-empty; an entry pops when dl_wr&dl_ready.
REQ-031 SHALL make a push into an empty FIFO visible on dl_* on the next cycle (latency 1).
REQ-032 SHALL keep dl_addr/dl_data stable while dl_wr=1 and dl_ready=0.
REQ-033 SHALL register ioctl_wait, asserting it when the FIFO holds 2 entries, or holds 1 entry with a push and no pop this cycle.
REQ-034 SHALL, when a push and a pop occur in the same cycle, keep the occupancy unchanged and preserve order.
REQ-035 SHALL, on a push while the FIFO is full, drop the byte and set err_range.
REQ-036 SHALL, on ioctl_wr with ioctl_index==DIP_INDEX and ioctl_addr[24:3]==0, write byte ioctl_addr[2:0] of dip_sw the next cycle, in any FSM state.
REQ-037 SHALL ignore writes carrying any other index.

Reset
REQ-038 SHALL, while reset=1, force: state IDLE, FIFO empty, counter 0, dip_sw=0, dl_wr=0, dl_addr=0, dl_data=0, ioctl_wait=0, core_reset=1, rom_ready=0, err_range=0, err_short=0.
REQ-039 SHALL, when reset occurs mid-LOAD, discard buffered bytes and stay in IDLE until the next ROM download rising edge.

Structure
REQ-040 SHALL place the FSM state enum and the default ROM_INDEX/DIP_INDEX constants in the shared core package.
REQ-041 SHALL implement the 2-entry FIFO as the sub-module rom_loader_fifo.

Verification
REQ-042 Load 0x28000 bytes with dl_ready=1 -> every byte appears once on dl_* in order; rom_ready rises exactly 16 cycles after the FIFO empties; err_short=0.
REQ-043 Hold dl_ready=0 while writing to 0x00000, 0x00001, 0x00002 -> ioctl_wait=1 after the second byte; the third byte is dropped and err_range=1; dl_addr stays 0x00000.
REQ-044 Write to addr 0x28000 during LOAD -> no dl_wr, err_range=1, byte counter unchanged.
REQ-045 End a download after 0x100 bytes -> err_short=1, rom_ready=1 after settle.
REQ-046 Send DIP index 254 with addr 0 data 0x5A and addr 8 data 0xFF -> dip_sw[7:0]=0x5A; the addr 8 write is ignored.
REQ-047 Assert reset mid-LOAD, then start a new download -> FIFO flushed, core_reset=1, the new load completes normally.
